// File: rtl/id_stage_pkg.sv
// Shared widths and helpers for the operand-collection stage.
// No logic of its own; imported by id_operand_stage and operand_snoop.
// R0 is the hard-wired zero register and is never bypassed.
package id_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] R0 = '0;

    // True when a register-file write lands on a real (nonzero) register we care about.
    function automatic logic snoop_hit(
        input logic              we,
        input logic [REG_AW-1:0] wr_reg,
        input logic [REG_AW-1:0] rd_reg
    );
        return we && (wr_reg == rd_reg) && (rd_reg != R0);
    endfunction

endpackage

// File: rtl/operand_snoop.sv
// Per-operand S1 state: register number, load-edge bypass and held value.
// Effective value is combinational from S1 state and the registered read data.
// While S1 stalls the value is frozen locally, so upstream may move its read address.
module operand_snoop
    import id_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic              hold,
    input  logic [REG_AW-1:0] load_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [REG_AW-1:0] ra,
    output logic [DATA_W-1:0] fwd
);

    logic              hit;
    logic [DATA_W-1:0] byp;
    logic [DATA_W-1:0] held;
    logic              res;
    logic [DATA_W-1:0] eff;
    logic              wr_match;

    // Resolve the operand: zero register, frozen value, load-edge bypass, then register file.
    always_comb begin
        eff = read_data;
        if (ra == R0)
            eff = '0;
        else if (res)
            eff = held;
        else if (hit)
            eff = byp;
    end

    // A write on the current edge is invisible to eff, so forward it explicitly.
    assign wr_match = snoop_hit(reg_write, write_reg, ra);
    assign fwd      = wr_match ? write_data : eff;

    // Capture on load (the read issued this edge misses a same-edge write), freeze on stall.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ra   <= '0;
            hit  <= 1'b0;
            byp  <= '0;
            held <= '0;
            res  <= 1'b0;
        end else if (load) begin
            ra   <= load_reg;
            hit  <= snoop_hit(reg_write, write_reg, load_reg);
            byp  <= write_data;
            res  <= 1'b0;
        end else if (hold) begin
            held <= fwd;
            res  <= 1'b1;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Operand collection after the synchronous-read register file, with write snooping.
// Latency: accept at edge k, Out_Valid after edge k+1; one instruction per cycle.
// Backpressure: S2 stalls on !Out_Ready, S1 then holds and In_Ready drops; Flush kills both.
module id_operand_stage
    import id_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [REG_AW-1:0] Read_Reg1,
    input  logic [REG_AW-1:0] Read_Reg2,
    input  logic [DATA_W-1:0] Read_Data1,
    input  logic [DATA_W-1:0] Read_Data2,
    input  logic              Reg_Write,
    input  logic [REG_AW-1:0] Write_Reg,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Op_A,
    output logic [DATA_W-1:0] Op_B,
    output logic [REG_AW-1:0] Op_A_Reg,
    output logic [REG_AW-1:0] Op_B_Reg
);

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_adv;
    logic              s1_load;
    logic              s1_hold;
    logic [REG_AW-1:0] ra_a;
    logic [REG_AW-1:0] ra_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign s1_adv    = s1_valid && (!s2_valid || Out_Ready);
    assign In_Ready  = !s1_valid || s1_adv;
    assign s1_load   = In_Valid && In_Ready && !Flush;
    assign s1_hold   = s1_valid && !s1_adv;
    assign Out_Valid = s2_valid;

    operand_snoop u_snoop_a (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (s1_load),
        .hold       (s1_hold),
        .load_reg   (Read_Reg1),
        .read_data  (Read_Data1),
        .reg_write  (Reg_Write),
        .write_reg  (Write_Reg),
        .write_data (Write_Data),
        .ra         (ra_a),
        .fwd        (fwd_a)
    );

    operand_snoop u_snoop_b (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (s1_load),
        .hold       (s1_hold),
        .load_reg   (Read_Reg2),
        .read_data  (Read_Data2),
        .reg_write  (Reg_Write),
        .write_reg  (Write_Reg),
        .write_data (Write_Data),
        .ra         (ra_b),
        .fwd        (fwd_b)
    );

    // Stage occupancy; Flush beats both load and advance.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (Flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;

            if (s1_adv)
                s2_valid <= 1'b1;
            else if (Out_Ready)
                s2_valid <= 1'b0;
        end
    end

    // S2 operands: take forwarded S1 values on advance, keep snooping writes while stalled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Op_A     <= '0;
            Op_B     <= '0;
            Op_A_Reg <= '0;
            Op_B_Reg <= '0;
        end else if (s1_adv) begin
            Op_A     <= fwd_a;
            Op_B     <= fwd_b;
            Op_A_Reg <= ra_a;
            Op_B_Reg <= ra_b;
        end else if (s2_valid && !Out_Ready) begin
            if (snoop_hit(Reg_Write, Write_Reg, Op_A_Reg))
                Op_A <= Write_Data;
            if (snoop_hit(Reg_Write, Write_Reg, Op_B_Reg))
                Op_B <= Write_Data;
        end
    end

endmodule
